// File: rtl/muldiv_sequencer_if.sv
// Pipeline-side bundle for the multi-cycle multiply/divide unit and its HI/LO registers.
// The EX stage drives the master side and the engine implements the slave side.
interface muldiv_sequencer_if #(
  parameter int XLEN = 32
);
  logic            start;
  logic [1:0]      op;
  logic [XLEN-1:0] rs_content;
  logic [XLEN-1:0] rt_content;
  logic            wr_hi;
  logic            wr_lo;
  logic [XLEN-1:0] wr_data;
  logic            rd_req;
  logic            busy;
  logic            done;
  logic            stall;
  logic [XLEN-1:0] HI;
  logic [XLEN-1:0] LO;

  modport master (
    output start, op, rs_content, rt_content, wr_hi, wr_lo, wr_data, rd_req,
    input  busy, done, stall, HI, LO
  );

  modport slave (
    input  start, op, rs_content, rt_content, wr_hi, wr_lo, wr_data, rd_req,
    output busy, done, stall, HI, LO
  );
endinterface

// File: rtl/muldiv_sequencer.sv
// Iterative MULT/MULTU/DIV/DIVU engine, one bit per cycle, owning the HI/LO registers.
// Signed operations run on magnitudes; signs are reapplied in a final FIX cycle.
module muldiv_sequencer #(
  parameter int XLEN = 32
) (
  input logic               clk,
  input logic               reset_n,
  muldiv_sequencer_if.slave bus
);
  localparam int CW = $clog2(XLEN);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2
  } state_e;

  state_e              state_q,   state_d;
  logic [CW-1:0]       cnt_q,     cnt_d;
  logic [2*XLEN-1:0]   work_q,    work_d;
  logic [XLEN-1:0]     opb_q,     opb_d;
  logic [XLEN-1:0]     hi_q,      hi_d;
  logic [XLEN-1:0]     lo_q,      lo_d;
  logic                is_div_q,  is_div_d;
  logic                sign_a_q,  sign_a_d;
  logic                sign_b_q,  sign_b_d;
  logic                divzero_q, divzero_d;
  logic                busy_q,    busy_d;
  logic                done_q,    done_d;

  // Launch-time operand conditioning: signed ops (op[0]==0) work on magnitudes.
  logic            op_signed;
  logic            rs_neg, rt_neg;
  logic [XLEN-1:0] rs_mag, rt_mag;

  assign op_signed = ~bus.op[0];
  assign rs_neg    = op_signed & bus.rs_content[XLEN-1];
  assign rt_neg    = op_signed & bus.rt_content[XLEN-1];
  assign rs_mag    = rs_neg ? -bus.rs_content : bus.rs_content;
  assign rt_mag    = rt_neg ? -bus.rt_content : bus.rt_content;

  // work_q holds {partial product, multiplier} for multiply and {remainder, quotient}
  // for divide; opb_q holds the multiplicand or the divisor.
  logic [XLEN:0]     mul_sum;
  logic [XLEN:0]     div_trial;
  logic              div_ge;
  logic [XLEN-1:0]   div_rem;
  logic [2*XLEN-1:0] iter_next;

  assign mul_sum   = {1'b0, work_q[2*XLEN-1:XLEN]} + (work_q[0] ? {1'b0, opb_q} : '0);
  assign div_trial = {work_q[2*XLEN-1:XLEN], work_q[XLEN-1]};
  assign div_ge    = (div_trial >= {1'b0, opb_q});
  // The subtracted result is always below the divisor, so the low XLEN bits suffice.
  assign div_rem   = div_ge ? (div_trial[XLEN-1:0] - opb_q) : div_trial[XLEN-1:0];
  assign iter_next = is_div_q ? {div_rem, work_q[XLEN-2:0], div_ge}
                              : {mul_sum, work_q[XLEN-1:1]};

  logic              signs_differ;
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quo_fix, rem_fix;

  assign signs_differ = sign_a_q ^ sign_b_q;
  assign prod_fix     = signs_differ ? -work_q : work_q;
  // Divide by zero leaves the dividend magnitude in the remainder, so restoring the
  // dividend sign reproduces rs exactly; only the quotient is forced.
  assign quo_fix      = divzero_q    ? '1
                      : signs_differ ? -work_q[XLEN-1:0] : work_q[XLEN-1:0];
  assign rem_fix      = sign_a_q ? -work_q[2*XLEN-1:XLEN] : work_q[2*XLEN-1:XLEN];

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    work_d    = work_q;
    opb_d     = opb_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    is_div_d  = is_div_q;
    sign_a_d  = sign_a_q;
    sign_b_d  = sign_b_q;
    divzero_d = divzero_q;
    done_d    = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (bus.wr_hi) hi_d = bus.wr_data;
        if (bus.wr_lo) lo_d = bus.wr_data;
        if (bus.start) begin
          is_div_d  = bus.op[1];
          sign_a_d  = rs_neg;
          sign_b_d  = rt_neg;
          divzero_d = bus.op[1] & (bus.rt_content == '0);
          work_d    = bus.op[1] ? {{XLEN{1'b0}}, rs_mag} : {{XLEN{1'b0}}, rt_mag};
          opb_d     = bus.op[1] ? rt_mag : rs_mag;
          cnt_d     = CW'(XLEN - 1);
          state_d   = S_RUN;
        end
      end
      S_RUN: begin
        work_d = iter_next;
        cnt_d  = cnt_q - CW'(1);
        if (cnt_q == '0) state_d = S_FIX;
      end
      S_FIX: begin
        if (is_div_q) begin
          hi_d = rem_fix;
          lo_d = quo_fix;
        end else begin
          hi_d = prod_fix[2*XLEN-1:XLEN];
          lo_d = prod_fix[XLEN-1:0];
        end
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // NOTE: state is updated with non-blocking assignments so every flop samples the
  // pre-edge value of every other flop, regardless of statement order.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      work_q    <= '0;
      opb_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      is_div_q  <= 1'b0;
      sign_a_q  <= 1'b0;
      sign_b_q  <= 1'b0;
      divzero_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      work_q    <= work_d;
      opb_q     <= opb_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      is_div_q  <= is_div_d;
      sign_a_q  <= sign_a_d;
      sign_b_q  <= sign_b_d;
      divzero_q <= divzero_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
  assign bus.stall = (bus.rd_req | bus.wr_hi | bus.wr_lo) & busy_q;
  assign bus.HI    = hi_q;
  assign bus.LO    = lo_q;
endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed bench for muldiv_sequencer: latency, arithmetic results, HI/LO access
// rules while busy, and mid-operation reset.
module tb_muldiv_sequencer;
  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    string       name;
  } vec_t;

  logic clk;
  logic reset_n;
  int   checks;
  int   errors;

  muldiv_sequencer_if #(.XLEN(32)) bus ();

  muldiv_sequencer #(.XLEN(32)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Start an operation, scramble the operand inputs, and return the cycle in which
  // done was seen (cycle 1 is the one right after the accepting edge).
  task automatic launch_and_wait(input logic [1:0] op, input logic [31:0] a,
                                 input logic [31:0] b, output int cyc);
    bus.op         = op;
    bus.rs_content = a;
    bus.rt_content = b;
    bus.start      = 1'b1;
    tick();
    bus.start      = 1'b0;
    bus.op         = ~op;
    bus.rs_content = ~a;
    bus.rt_content = b + 32'd1;
    cyc = 1;
    while (bus.done !== 1'b1 && cyc < 100) begin
      tick();
      cyc++;
    end
  endtask

  task automatic test_reset();
    reset_n    = 1'b0;
    bus.rd_req = 1'b1;
    tick();
    tick();
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", bus.done); end
    checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b expected 0", bus.stall); end
    checks++; if (bus.HI !== 32'h0) begin errors++; $display("FAIL reset_hi: got %h expected 00000000", bus.HI); end
    checks++; if (bus.LO !== 32'h0) begin errors++; $display("FAIL reset_lo: got %h expected 00000000", bus.LO); end
    bus.rd_req = 1'b0;
    reset_n    = 1'b1;
    tick();
  endtask

  task automatic test_mt_idle();
    bus.wr_hi = 1'b1; bus.wr_data = 32'hA5A5A5A5;
    tick();
    bus.wr_hi = 1'b0;
    checks++; if (bus.HI !== 32'hA5A5A5A5) begin errors++; $display("FAIL mthi: got %h expected a5a5a5a5", bus.HI); end
    bus.wr_lo = 1'b1; bus.wr_data = 32'h5A5A5A5A;
    tick();
    bus.wr_lo = 1'b0;
    checks++; if (bus.LO !== 32'h5A5A5A5A) begin errors++; $display("FAIL mtlo: got %h expected 5a5a5a5a", bus.LO); end
    checks++; if (bus.HI !== 32'hA5A5A5A5) begin errors++; $display("FAIL mtlo_hi_hold: got %h expected a5a5a5a5", bus.HI); end
    bus.wr_hi = 1'b1; bus.wr_lo = 1'b1; bus.wr_data = 32'h13572468;
    tick();
    bus.wr_hi = 1'b0; bus.wr_lo = 1'b0;
    checks++; if (bus.HI !== 32'h13572468) begin errors++; $display("FAIL mt_both_hi: got %h expected 13572468", bus.HI); end
    checks++; if (bus.LO !== 32'h13572468) begin errors++; $display("FAIL mt_both_lo: got %h expected 13572468", bus.LO); end
  endtask

  task automatic run_table(input vec_t v[]);
    int cyc;
    foreach (v[i]) begin
      launch_and_wait(v[i].op, v[i].a, v[i].b, cyc);
      checks++; if (cyc !== 34) begin errors++; $display("FAIL %s_latency: got %0d expected 34", v[i].name, cyc); end
      checks++; if (bus.HI !== v[i].hi) begin errors++; $display("FAIL %s_hi: got %h expected %h", v[i].name, bus.HI, v[i].hi); end
      checks++; if (bus.LO !== v[i].lo) begin errors++; $display("FAIL %s_lo: got %h expected %h", v[i].name, bus.LO, v[i].lo); end
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL %s_busy_at_done: got %b expected 0", v[i].name, bus.busy); end
      tick();
      checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL %s_done_pulse: got %b expected 0", v[i].name, bus.done); end
    end
  endtask

  task automatic test_mult();
    vec_t v[];
    v = new[4];
    v[0] = '{OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, "multu_max"};
    v[1] = '{OP_MULT,  32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFF, 32'hFFFFFFFA, "mult_neg2x3"};
    v[2] = '{OP_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, "mult_minxmin"};
    v[3] = '{OP_MULT,  32'h00000007, 32'hFFFFFFF7, 32'hFFFFFFFF, 32'hFFFFFFC1, "mult_7xneg9"};
    run_table(v);
  endtask

  task automatic test_div();
    vec_t v[];
    v = new[5];
    v[0] = '{OP_DIV,  32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, "div_neg7by2"};
    v[1] = '{OP_DIV,  32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, "div_overflow"};
    v[2] = '{OP_DIVU, 32'h00000064, 32'h00000007, 32'h00000002, 32'h0000000E, "divu_100by7"};
    v[3] = '{OP_DIV,  32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, "div_7byneg2"};
    v[4] = '{OP_DIVU, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 32'hFFFFFFFF, "divu_maxby1"};
    run_table(v);
  endtask

  task automatic test_divzero();
    vec_t v[];
    v = new[2];
    v[0] = '{OP_DIVU, 32'h00001234, 32'h00000000, 32'h00001234, 32'hFFFFFFFF, "divu_by0"};
    v[1] = '{OP_DIV,  32'hFFFFFFFB, 32'h00000000, 32'hFFFFFFFB, 32'hFFFFFFFF, "div_neg_by0"};
    run_table(v);
  endtask

  task automatic test_mt_with_start();
    int cyc;
    bus.wr_hi = 1'b1; bus.wr_data = 32'h0000CAFE;
    bus.op = OP_MULTU; bus.rs_content = 32'd2; bus.rt_content = 32'd3; bus.start = 1'b1;
    tick();
    bus.wr_hi = 1'b0; bus.start = 1'b0;
    checks++; if (bus.HI !== 32'h0000CAFE) begin errors++; $display("FAIL mt_at_start_hi: got %h expected 0000cafe", bus.HI); end
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL mt_at_start_busy: got %b expected 1", bus.busy); end
    cyc = 1;
    while (bus.done !== 1'b1 && cyc < 100) begin tick(); cyc++; end
    checks++; if (cyc !== 34) begin errors++; $display("FAIL mt_at_start_latency: got %0d expected 34", cyc); end
    checks++; if (bus.HI !== 32'h0) begin errors++; $display("FAIL mt_at_start_result_hi: got %h expected 00000000", bus.HI); end
    checks++; if (bus.LO !== 32'h6) begin errors++; $display("FAIL mt_at_start_result_lo: got %h expected 00000006", bus.LO); end
    tick();
  endtask

  task automatic test_stall_busy();
    bus.wr_lo = 1'b1; bus.wr_data = 32'h11111111;
    tick();
    bus.wr_lo = 1'b0;
    bus.op = OP_MULTU; bus.rs_content = 32'd3; bus.rt_content = 32'd5; bus.start = 1'b1;
    tick();
    bus.start  = 1'b0;
    bus.rd_req = 1'b1;
    for (int cyc = 1; cyc <= 33; cyc++) begin
      if (cyc == 5) begin
        bus.start = 1'b1; bus.op = OP_DIVU; bus.rs_content = 32'd100; bus.rt_content = 32'd7;
      end else begin
        bus.start = 1'b0;
      end
      bus.wr_lo   = (cyc == 10);
      bus.wr_data = 32'hDEADBEEF;
      #1;
      checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL busy_c%0d: got %b expected 1", cyc, bus.busy); end
      checks++; if (bus.stall !== 1'b1) begin errors++; $display("FAIL stall_c%0d: got %b expected 1", cyc, bus.stall); end
      checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL early_done_c%0d: got %b expected 0", cyc, bus.done); end
      if (cyc == 11) begin
        checks++; if (bus.LO !== 32'h11111111) begin errors++; $display("FAIL mtlo_while_busy: got %h expected 11111111", bus.LO); end
      end
      tick();
    end
    bus.start = 1'b0; bus.wr_lo = 1'b0;
    #1;
    checks++; if (bus.done !== 1'b1) begin errors++; $display("FAIL done_c34: got %b expected 1", bus.done); end
    checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL stall_c34: got %b expected 0", bus.stall); end
    checks++; if (bus.LO !== 32'd15) begin errors++; $display("FAIL stall_result_lo: got %h expected 0000000f", bus.LO); end
    checks++; if (bus.HI !== 32'd0) begin errors++; $display("FAIL stall_result_hi: got %h expected 00000000", bus.HI); end
    tick();
    bus.rd_req = 1'b0;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL start_not_queued: got %b expected 0", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL done_c35: got %b expected 0", bus.done); end
  endtask

  task automatic test_reset_abort();
    int  cyc;
    bit  seen;
    bus.wr_hi = 1'b1; bus.wr_data = 32'h77777777;
    tick();
    bus.wr_hi = 1'b0;
    bus.op = OP_MULT; bus.rs_content = 32'd7; bus.rt_content = 32'd9; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    repeat (9) tick();
    reset_n = 1'b0;
    tick();
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b expected 0", bus.busy); end
    checks++; if (bus.HI !== 32'h0) begin errors++; $display("FAIL abort_hi: got %h expected 00000000", bus.HI); end
    checks++; if (bus.LO !== 32'h0) begin errors++; $display("FAIL abort_lo: got %h expected 00000000", bus.LO); end
    reset_n = 1'b1;
    seen = 1'b0;
    repeat (40) begin
      tick();
      if (bus.done === 1'b1 || bus.busy === 1'b1) seen = 1'b1;
    end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL abort_no_done: got %b expected 0", seen); end
    checks++; if (bus.LO !== 32'h0) begin errors++; $display("FAIL abort_lo_hold: got %h expected 00000000", bus.LO); end
    launch_and_wait(OP_MULT, 32'hFFFFFFFD, 32'd5, cyc);
    checks++; if (cyc !== 34) begin errors++; $display("FAIL after_abort_latency: got %0d expected 34", cyc); end
    checks++; if (bus.HI !== 32'hFFFFFFFF) begin errors++; $display("FAIL after_abort_hi: got %h expected ffffffff", bus.HI); end
    checks++; if (bus.LO !== 32'hFFFFFFF1) begin errors++; $display("FAIL after_abort_lo: got %h expected fffffff1", bus.LO); end
    tick();
  endtask

  initial begin
    checks         = 0;
    errors         = 0;
    reset_n        = 1'b0;
    bus.start      = 1'b0;
    bus.op         = 2'b00;
    bus.rs_content = '0;
    bus.rt_content = '0;
    bus.wr_hi      = 1'b0;
    bus.wr_lo      = 1'b0;
    bus.wr_data    = '0;
    bus.rd_req     = 1'b0;

    test_reset();
    test_mt_idle();
    test_mult();
    test_div();
    test_divzero();
    test_mt_with_start();
    test_stall_busy();
    test_reset_abort();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
